pc_gen: RTL

- Parametrised next-generation program-counter generator for the NPC core front end.
- Holds the fetch PC and offers it to instruction fetch over a valid/ready handshake.
- Advances sequentially on each accepted fetch.
- Applies control-flow redirects by fixed priority: trap, then mret, then branch/jal/jalr.
- Detects misaligned jump targets and reports them instead of redirecting.

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_target_calc.sv | 41 ++++
 rtl/pc_gen.sv | 108 ++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared front-end configuration: datapath width, reset PC and redirect op encodings.
package pc_gen_pkg;

  localparam int          XLEN          = 64;
  localparam logic [63:0] PC_RESET_ADDR = 64'h8000_0000;
  localparam int          PCOP_LEN      = 3;

  typedef enum logic [PCOP_LEN-1:0] {
    PCOP_NONE   = 3'd0,
    PCOP_INC4   = 3'd1,
    PCOP_BRANCH = 3'd2,
    PCOP_JAL    = 3'd3,
    PCOP_JALR   = 3'd4
  } pcop_e;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-flow target: adder, jalr bit-0 clear and alignment check.
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = pc_gen_pkg::XLEN,
  parameter bit C_EXT = 1'b0
) (
  input  logic [PCOP_LEN-1:0] op,
  input  logic [XLEN-1:0]     base,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     imm,
  input  logic                br_taken,
  output logic                redirect,
  output logic [XLEN-1:0]     target,
  output logic                misaligned
);

  logic [XLEN-1:0] sum_pc;
  logic [XLEN-1:0] sum_rs1;

  assign sum_pc  = base + imm;
  assign sum_rs1 = rs1 + imm;

  always_comb begin
    redirect = 1'b0;
    target   = sum_pc;
    case (op)
      PCOP_BRANCH: redirect = br_taken;
      PCOP_JAL:    redirect = 1'b1;
      PCOP_JALR: begin
        redirect = 1'b1;
        target   = {sum_rs1[XLEN-1:1], 1'b0};
      end
      default: redirect = 1'b0;
    endcase
  end

  // With compressed instructions only bit 0 must be clear; otherwise word alignment.
  assign misaligned = redirect & (C_EXT ? target[0] : (|target[1:0]));

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with valid/ready fetch handshake and prioritised redirects.
//
//   state   | meaning
//   ST_BOOT | first cycle after reset, no fetch request offered
//   ST_RUN  | fetch_pc offered to fetch every cycle
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = pc_gen_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(PC_RESET_ADDR),
  parameter bit              C_EXT      = 1'b0,
  parameter int              INC        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [PCOP_LEN-1:0] redirect_op,
  input  logic [XLEN-1:0]     redirect_base,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     imm_data,
  input  logic                br_taken,
  input  logic                trap_valid,
  input  logic [XLEN-1:0]     trap_vec,
  input  logic                mret_valid,
  input  logic [XLEN-1:0]     mepc,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  output logic [XLEN-1:0]     fetch_pc,
  output logic                misalign_err,
  output logic [XLEN-1:0]     misalign_addr
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic            calc_redirect;
  logic [XLEN-1:0] calc_target;
  logic            calc_misaligned;
  logic            eff_redirect;
  logic            fire;

  pc_target_calc #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_target (
    .op         (redirect_op),
    .base       (redirect_base),
    .rs1        (rs1_data),
    .imm        (imm_data),
    .br_taken   (br_taken),
    .redirect   (calc_redirect),
    .target     (calc_target),
    .misaligned (calc_misaligned)
  );

  assign eff_redirect = redirect_valid & calc_redirect;
  assign fire         = fetch_valid & fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_ADDR;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // A redirect outranks a same-cycle fire; the fired PC is simply dropped.
  always_comb begin
    pc_d   = pc_q;
    err_d  = 1'b0;
    addr_d = addr_q;
    if (trap_valid) begin
      pc_d = trap_vec;
    end else if (mret_valid) begin
      pc_d = mepc;
    end else if (eff_redirect && !calc_misaligned) begin
      pc_d = calc_target;
    end else if (eff_redirect) begin
      err_d  = 1'b1;
      addr_d = calc_target;
    end else if (fire) begin
      pc_d = pc_q + XLEN'(INC);
    end
  end

  assign fetch_valid   = (state_q == ST_RUN);
  assign fetch_pc      = pc_q;
  assign misalign_err  = err_q;
  assign misalign_addr = addr_q;

endmodule
